mult_accumulator: RTL and testbench

//  Multiply-accumulate stage built around the MULTS 8x8 structural multiplier.

---
 rtl/mult_accumulator_if.sv | 35 +++
 rtl/mult_accumulator.sv | 133 +++++++++++++
 tb/tb_mult_accumulator.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_accumulator_if.sv
// ============================================================================
// Module   : mult_accumulator_if
// Brief    : Command, operand-stream and result-stream bundle for mult_accumulator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mult_accumulator_if #(
    parameter int CNT_W = 8,
    parameter int ACC_W = 24
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a;
    logic [7:0]       x;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;
    logic             busy;

    modport master (
        output start, len, in_valid, a, x, out_ready,
        input  in_ready, out_valid, acc_out, overflow, busy
    );

    modport slave (
        input  start, len, in_valid, a, x, out_ready,
        output in_ready, out_valid, acc_out, overflow, busy
    );
endinterface

`default_nettype wire

// File: rtl/mult_accumulator.sv
// ============================================================================
// Module   : mult_accumulator
// Brief    : Burst multiply-accumulate: 8x8 unsigned products summed into ACC_W bits.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    mult_accumulator_if.slave  s_if
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] rem_q;
    logic [7:0]       a_q;
    logic [7:0]       x_q;
    logic             v_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             w_xfer;
    logic             w_handshake;
    logic [15:0]      w_pp [8];
    logic [15:0]      w_prod;
    logic [ACC_W:0]   acc_d;

    assign w_xfer      = s_if.in_valid & in_ready_q;
    assign w_handshake = out_valid_q & s_if.out_ready;

    // Shift-and-add array: one gated, shifted copy of a_q per multiplier bit.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pp
        assign w_pp[gi] = {8'd0, a_q & {8{x_q[gi]}}} << gi;
    end

    always_comb begin
        w_prod = '0;
        for (int i = 0; i < 8; i++) begin
            w_prod = w_prod + w_pp[i];
        end
    end

    assign acc_d = {1'b0, acc_q} + (ACC_W+1)'(w_prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            a_q         <= '0;
            x_q         <= '0;
            v_q         <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            v_q <= 1'b0;
            if (v_q) begin
                acc_q <= acc_d[ACC_W-1:0];
                if (acc_d[ACC_W]) begin
                    ovf_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (s_if.start) begin
                        acc_q  <= '0;
                        ovf_q  <= 1'b0;
                        rem_q  <= s_if.len;
                        busy_q <= 1'b1;
                        if (s_if.len == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q    <= S_ACC;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                S_ACC: begin
                    if (w_xfer) begin
                        a_q   <= s_if.a;
                        x_q   <= s_if.x;
                        v_q   <= 1'b1;
                        rem_q <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q    <= S_DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    // out_valid rises one cycle after entry, once the sum has settled.
                    if (w_handshake) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign s_if.in_ready  = in_ready_q;
    assign s_if.out_valid = out_valid_q;
    assign s_if.acc_out   = acc_q;
    assign s_if.overflow  = ovf_q;
    assign s_if.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_accumulator.sv
// ============================================================================
// Module   : tb_mult_accumulator
// Brief    : Scoreboard bench for mult_accumulator (24-bit and 16-bit instances).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mult_accumulator;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mult_accumulator_if #(.CNT_W(8), .ACC_W(24)) m24 ();
    mult_accumulator_if #(.CNT_W(8), .ACC_W(16)) m16 ();

    mult_accumulator #(.ACC_W(24), .CNT_W(8)) u_dut24 (.clk(clk), .rst(rst), .s_if(m24));
    mult_accumulator #(.ACC_W(16), .CNT_W(8)) u_dut16 (.clk(clk), .rst(rst), .s_if(m16));

    typedef struct {
        logic [23:0] acc;
        logic        ovf;
    } exp_t;

    exp_t sb [$];
    int   checks     = 0;
    int   errors     = 0;
    int   xfers      = 0;
    int   ready_seen = 0;

    always @(posedge clk) begin
        if (m24.in_valid && m24.in_ready) xfers++;
        if (m24.in_ready) ready_seen++;
    end

    task automatic send24(input logic [7:0] a, input logic [7:0] x, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            m24.in_valid = 1'b0;
            m24.a = 8'($urandom);
            m24.x = 8'($urandom);
            @(posedge clk); #1;
        end
        m24.in_valid = 1'b1;
        m24.a = a;
        m24.x = x;
        t = 0;
        while (!m24.in_ready && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 40) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%0b required 1", m24.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m24.in_ready, m24.out_valid, m24.overflow, m24.busy, m24.acc_out} !== '0) begin
            errors++;
            $display("FAIL reset24 rdy=%0b ov=%0b of=%0b busy=%0b acc=%0d required all 0",
                     m24.in_ready, m24.out_valid, m24.overflow, m24.busy, m24.acc_out);
        end
        checks++;
        if ({m16.in_ready, m16.out_valid, m16.overflow, m16.busy, m16.acc_out} !== '0) begin
            errors++;
            $display("FAIL reset16 rdy=%0b ov=%0b of=%0b busy=%0b acc=%0d required all 0",
                     m16.in_ready, m16.out_valid, m16.overflow, m16.busy, m16.acc_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [24:0] s;
        exp_t        e;
        s = '0;
        m24.start = 1'b1; m24.len = 8'd3;
        @(posedge clk); #1;
        m24.start = 1'b0;
        checks++;
        if ({m24.busy, m24.in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL t1_start busy/in_ready=%b required 11", {m24.busy, m24.in_ready});
        end
        send24(8'd2, 8'd3, 0);     s = s + 25'(2 * 3);
        send24(8'd4, 8'd5, 0);     s = s + 25'(4 * 5);
        send24(8'd255, 8'd255, 0); s = s + 25'(255 * 255);
        m24.in_valid = 1'b0;
        e.acc = s[23:0]; e.ovf = s[24];
        sb.push_back(e);
        @(posedge clk); #1;
        checks++;
        if (m24.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_latency_early out_valid=%0b required 0", m24.out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (m24.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL t1_latency out_valid=%0b required 1", m24.out_valid);
        end
        e = sb.pop_front();
        checks++;
        if (m24.acc_out !== e.acc || m24.overflow !== e.ovf) begin
            errors++;
            $display("FAIL t1_result acc=%0d ovf=%0b required acc=%0d ovf=%0b",
                     m24.acc_out, m24.overflow, e.acc, e.ovf);
        end
        m24.out_ready = 1'b1;
        @(posedge clk); #1;
        m24.out_ready = 1'b0;
        checks++;
        if ({m24.out_valid, m24.busy} !== 2'b00) begin
            errors++;
            $display("FAIL t1_release out_valid/busy=%b required 00", {m24.out_valid, m24.busy});
        end
    endtask

    task automatic test_zero_len;
        int   r0;
        exp_t e;
        r0 = ready_seen;
        e.acc = '0; e.ovf = 1'b0;
        sb.push_back(e);
        m24.start = 1'b1; m24.len = 8'd0;
        @(posedge clk); #1;
        m24.start = 1'b0;
        checks++;
        if (m24.out_valid !== 1'b0 || m24.busy !== 1'b1) begin
            errors++;
            $display("FAIL t2_early out_valid=%0b busy=%0b required 0 1", m24.out_valid, m24.busy);
        end
        @(posedge clk); #1;
        checks++;
        if (m24.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL t2_latency out_valid=%0b required 1", m24.out_valid);
        end
        e = sb.pop_front();
        checks++;
        if (m24.acc_out !== e.acc || m24.overflow !== e.ovf) begin
            errors++;
            $display("FAIL t2_result acc=%0d ovf=%0b required acc=%0d ovf=%0b",
                     m24.acc_out, m24.overflow, e.acc, e.ovf);
        end
        m24.out_ready = 1'b1;
        @(posedge clk); #1;
        m24.out_ready = 1'b0;
        checks++;
        if (ready_seen - r0 !== 0) begin
            errors++;
            $display("FAIL t2_in_ready cycles_high=%0d required 0", ready_seen - r0);
        end
    endtask

    task automatic test_gaps_backpressure;
        logic [24:0] s;
        exp_t        e;
        int          t;
        logic        hold_ok;
        int          gaps [4] = '{0, 2, 1, 3};
        s = '0;
        m24.start = 1'b1; m24.len = 8'd4;
        @(posedge clk); #1;
        m24.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send24(8'd3, 8'd3, gaps[i]);
            s = s + 25'(3 * 3);
        end
        m24.in_valid = 1'b0;
        e.acc = s[23:0]; e.ovf = s[24];
        sb.push_back(e);
        t = 0;
        while (!m24.out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (m24.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL t3_timeout out_valid=%0b required 1", m24.out_valid);
        end
        e = sb.pop_front();
        hold_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (m24.out_valid !== 1'b1 || m24.acc_out !== e.acc || m24.overflow !== e.ovf) hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (!hold_ok || m24.acc_out !== e.acc) begin
            errors++;
            $display("FAIL t3_hold acc=%0d out_valid=%0b required acc=%0d held valid",
                     m24.acc_out, m24.out_valid, e.acc);
        end
        m24.out_ready = 1'b1;
        @(posedge clk); #1;
        m24.out_ready = 1'b0;
        checks++;
        if ({m24.out_valid, m24.busy} !== 2'b00 || m24.acc_out !== e.acc) begin
            errors++;
            $display("FAIL t3_release valid/busy=%b acc=%0d required 00 acc=%0d",
                     {m24.out_valid, m24.busy}, m24.acc_out, e.acc);
        end
    endtask

    task automatic test_overflow16;
        logic [16:0] s;
        int          t;
        s = '0;
        m16.start = 1'b1; m16.len = 8'd2;
        @(posedge clk); #1;
        m16.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m16.in_valid = 1'b1; m16.a = 8'd255; m16.x = 8'd255;
            t = 0;
            while (!m16.in_ready && t < 40) begin
                @(posedge clk); #1;
                t++;
            end
            @(posedge clk); #1;
            s = s + 17'(255 * 255);
        end
        m16.in_valid = 1'b0;
        t = 0;
        while (!m16.out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (m16.acc_out !== s[15:0] || m16.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL t4_acc acc=%0d valid=%0b required acc=%0d valid=1",
                     m16.acc_out, m16.out_valid, s[15:0]);
        end
        checks++;
        if (m16.overflow !== 1'b1) begin
            errors++;
            $display("FAIL t4_overflow ovf=%0b required 1", m16.overflow);
        end
        m16.out_ready = 1'b1;
        @(posedge clk); #1;
        m16.out_ready = 1'b0;
    endtask

    task automatic test_reset_midburst;
        exp_t e;
        int   t;
        m24.start = 1'b1; m24.len = 8'd4;
        @(posedge clk); #1;
        m24.start = 1'b0;
        send24(8'd5, 8'd6, 0);
        send24(8'd7, 8'd8, 0);
        m24.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({m24.in_ready, m24.out_valid, m24.overflow, m24.busy, m24.acc_out} !== '0) begin
            errors++;
            $display("FAIL t5_reset rdy=%0b ov=%0b of=%0b busy=%0b acc=%0d required all 0",
                     m24.in_ready, m24.out_valid, m24.overflow, m24.busy, m24.acc_out);
        end
        m24.start = 1'b1; m24.len = 8'd1;
        @(posedge clk); #1;
        m24.start = 1'b0;
        send24(8'd1, 8'd1, 0);
        m24.in_valid = 1'b0;
        e.acc = 24'd1; e.ovf = 1'b0;
        sb.push_back(e);
        t = 0;
        while (!m24.out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        e = sb.pop_front();
        checks++;
        if (m24.out_valid !== 1'b1 || m24.acc_out !== e.acc || m24.overflow !== e.ovf) begin
            errors++;
            $display("FAIL t5_result valid=%0b acc=%0d ovf=%0b required 1 acc=%0d ovf=%0b",
                     m24.out_valid, m24.acc_out, m24.overflow, e.acc, e.ovf);
        end
        m24.out_ready = 1'b1;
        @(posedge clk); #1;
        m24.out_ready = 1'b0;
    endtask

    task automatic test_long_burst;
        logic [24:0] s;
        exp_t        e;
        int          x0;
        int          t;
        s = '0;
        x0 = xfers;
        m24.start = 1'b1; m24.len = 8'd255;
        @(posedge clk); #1;
        m24.start = 1'b0;
        for (int i = 0; i < 255; i++) begin
            if (i == 100) begin
                m24.start = 1'b1; m24.len = 8'd7;
            end
            send24(8'd255, 8'd255, (i % 37 == 5) ? 1 : 0);
            m24.start = 1'b0;
            s = s + 25'(255 * 255);
        end
        e.acc = s[23:0]; e.ovf = s[24];
        sb.push_back(e);
        // Keep offering pairs to prove the block stops accepting after len.
        repeat (3) @(posedge clk);
        #1;
        m24.in_valid = 1'b0;
        t = 0;
        while (!m24.out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        e = sb.pop_front();
        checks++;
        if (m24.out_valid !== 1'b1 || m24.acc_out !== e.acc || m24.overflow !== e.ovf) begin
            errors++;
            $display("FAIL t6_result valid=%0b acc=%0d ovf=%0b required 1 acc=%0d ovf=%0b",
                     m24.out_valid, m24.acc_out, m24.overflow, e.acc, e.ovf);
        end
        checks++;
        if (xfers - x0 !== 255) begin
            errors++;
            $display("FAIL t6_transfers count=%0d required 255", xfers - x0);
        end
        m24.start = 1'b1; m24.len = 8'd1; m24.out_ready = 1'b1;
        @(posedge clk); #1;
        m24.start = 1'b0; m24.out_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({m24.busy, m24.in_ready, m24.out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL t6_start_in_done busy/rdy/valid=%b required 000",
                     {m24.busy, m24.in_ready, m24.out_valid});
        end
    endtask

    initial begin
        rst = 1'b1;
        m24.start = 1'b0; m24.len = '0; m24.in_valid = 1'b0; m24.a = '0; m24.x = '0; m24.out_ready = 1'b0;
        m16.start = 1'b0; m16.len = '0; m16.in_valid = 1'b0; m16.a = '0; m16.x = '0; m16.out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_zero_len();
        test_gaps_backpressure();
        test_overflow16();
        test_reset_midburst();
        test_long_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
